// File: rtl/mul_seq_if.sv
//------------------------------------------------------------------------------
// mul_seq_if : operand/product bus of the sequential 32x32 multiplier
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mul_seq_if;
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic        start;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        over;

    modport master (
        output a, b, sign, start,
        input  hi, lo, busy, over
    );

    modport slave (
        input  a, b, sign, start,
        output hi, lo, busy, over
    );
endinterface

`default_nettype wire

// File: rtl/mul_seq.sv
//------------------------------------------------------------------------------
// mul_seq : 32x32 shift-add multiplier (MULT/MULTU), 33-cycle start/busy/over
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mul_seq (
    input  logic   clock,
    input  logic   reset,
    mul_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mq_q, mq_d;
    logic [31:0] mc_q, mc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [5:0]  count_q, count_d;
    logic        neg_q, neg_d;
    logic        sign_l_q, sign_l_d;
    logic        over_q, over_d;

    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_sum;
    logic [63:0] w_raw;
    logic [63:0] w_prod;

    // Magnitudes; -2^31 maps onto 0x80000000, already the right unsigned value.
    always_comb begin
        w_a_mag = (bus.sign && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
        w_b_mag = (bus.sign && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
        w_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mc_q} : 33'd0);
        w_raw   = {acc_q, mq_q};
        w_prod  = (neg_q && sign_l_q) ? (~w_raw + 64'd1) : w_raw;
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        mc_d     = mc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        count_d  = count_q;
        neg_d    = neg_q;
        sign_l_d = sign_l_q;
        over_d   = 1'b0;

        // start wins in every state, including FIN, so an abort never writes hi/lo
        if (bus.start) begin
            state_d  = RUN;
            acc_d    = 32'd0;
            mq_d     = w_b_mag;
            mc_d     = w_a_mag;
            count_d  = 6'd0;
            neg_d    = bus.sign & (bus.a[31] ^ bus.b[31]);
            sign_l_d = bus.sign;
        end else begin
            case (state_q)
                RUN: begin
                    acc_d   = w_sum[32:1];
                    mq_d    = {w_sum[0], mq_q[31:1]};
                    count_d = count_q + 6'd1;
                    if (count_q == 6'd31) begin
                        state_d = FIN;
                    end
                end
                FIN: begin
                    hi_d    = w_prod[63:32];
                    lo_d    = w_prod[31:0];
                    over_d  = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= 32'd0;
            mq_q     <= 32'd0;
            mc_q     <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            count_q  <= 6'd0;
            neg_q    <= 1'b0;
            sign_l_q <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            mc_q     <= mc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
            sign_l_q <= sign_l_d;
            over_q   <= over_d;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.over = over_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_seq.sv
//------------------------------------------------------------------------------
// tb_mul_seq : scoreboard bench for mul_seq (directed operand vectors)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mul_seq;

    logic clock;
    logic reset;

    mul_seq_if bus ();

    mul_seq dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [63:0] p;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc;
    int          checks;
    int          errors;
    logic [63:0] shadow;
    logic        start_seen;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) begin
        cyc        <= cyc + 1;
        start_seen <= bus.start;
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: pops the scoreboard on every over pulse; otherwise hi/lo must hold.
    initial begin
        exp_t e;
        checks = 0;
        errors = 0;
        shadow = 64'd0;
        forever begin
            @(negedge clock);
            if (reset) begin
                shadow = 64'd0;
                chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
                chk("reset_busy", {63'd0, bus.busy}, 64'd0);
                chk("reset_over", {63'd0, bus.over}, 64'd0);
            end else if (bus.over) begin
                if (q.size() == 0) begin
                    chk("unexpected_over", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("product", {bus.hi, bus.lo}, e.p);
                    chk("latency_cycle", 64'(cyc), 64'(e.cyc));
                    chk("busy_at_over", {63'd0, bus.busy}, 64'd0);
                    shadow = e.p;
                end
            end else begin
                chk("hilo_hold", {bus.hi, bus.lo}, shadow);
                if (start_seen)
                    chk("busy_after_start", {63'd0, bus.busy}, 64'd1);
                if (q.size() != 0 && cyc > q[0].cyc + 4) begin
                    chk("over_timeout", 64'(cyc), 64'(q[0].cyc));
                    void'(q.pop_front());
                end
            end
        end
    end

    // Drives start for one cycle; the start edge E0 is the posedge after cyc.
    task automatic issue(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                         input bit push, input logic [63:0] p);
        exp_t e;
        @(negedge clock);
        bus.a     = ta;
        bus.b     = tbv;
        bus.sign  = ts;
        bus.start = 1'b1;
        if (push) begin
            e.p   = p;
            e.cyc = cyc + 34;
            q.push_back(e);
        end
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            #1;
            if (q.size() == 0) break;
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.sign  = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;

        issue(32'd7, 32'd3, 1'b0, 1, 64'h00000000_00000015); wait_idle();
        issue(32'hFFFFFFF9, 32'd3, 1'b1, 1, 64'hFFFFFFFF_FFFFFFEB); wait_idle();
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1, 64'hFFFFFFFE_00000001); wait_idle();
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1, 64'h00000000_00000001); wait_idle();
        issue(32'h80000000, 32'h80000000, 1'b1, 1, 64'h40000000_00000000); wait_idle();
        issue(32'h80000000, 32'd1, 1'b1, 1, 64'hFFFFFFFF_80000000); wait_idle();
        issue(32'h80000000, 32'd2, 1'b0, 1, 64'h00000001_00000000); wait_idle();
        issue(32'h80000000, 32'd2, 1'b1, 1, 64'hFFFFFFFF_00000000); wait_idle();
        issue(32'd0, 32'hDEADBEEF, 1'b1, 1, 64'd0); wait_idle();

        // Restart at E10 with garbage operands applied from E1.
        issue(32'd6, 32'd7, 1'b0, 0, 64'd0);
        bus.a = 32'hA5A5A5A5;
        bus.b = 32'h5A5A5A5A;
        repeat (8) @(negedge clock);
        issue(32'd5, 32'd5, 1'b0, 1, 64'd25); wait_idle();

        // Operands changed after E0 must not disturb the result.
        issue(32'd6, 32'd7, 1'b0, 1, 64'd42);
        bus.a    = 32'hFFFFFFFF;
        bus.b    = 32'h12345678;
        bus.sign = 1'b1;
        wait_idle();

        // Start on the FIN edge aborts the first op; only the second completes.
        issue(32'd11, 32'd13, 1'b0, 0, 64'd0);
        repeat (31) @(negedge clock);
        issue(32'd3, 32'hFFFFFFFE, 1'b1, 1, 64'hFFFFFFFF_FFFFFFFA); wait_idle();

        // Immediate back-to-back after completion is not an abort.
        issue(32'd100, 32'd100, 1'b0, 1, 64'd10000); wait_idle();
        issue(32'hFFFFFFFF, 32'd2, 1'b0, 1, 64'h00000001_FFFFFFFE); wait_idle();

        // Reset mid-operation: clears outputs at once, no completion follows.
        issue(32'd9, 32'd9, 1'b0, 0, 64'd0);
        repeat (14) @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #2 reset = 1'b0;
        repeat (40) @(negedge clock);

        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
